mvm_engine: RTL and testbench
=============================

Name: mvm_engine

Overview:
- Parametrised successor to dot_prod: computes y = W·x for an NROW x NCOL signed fixed-point matrix held column-wise in weightRAM.
- Columns are streamed serially, one per cycle. Each column is processed by PAR_ROWS lanes, with NROW/PAR_ROWS row passes.
- Adds over the previous generation: start/busy/done handshake, held output with acknowledge, full-precision accumulation, round-half-up and saturation.
- Sits between weightRAM/input-vector storage and the next RNN stage (activation unit).

Parameters:
- NROW, 32: matrix rows (output vector length).
- NCOL, 4: matrix columns (input vector length); any value >= 2.
- QN, 6: integer bits.
- QM, 11: fractional bits; BITWIDTH = QN+QM+1.
- PAR_ROWS, 32: rows computed in parallel per pass; must divide NROW; NPASS = NROW/PAR_ROWS.
- ADDR_BITWIDTH, log2(NCOL)+1: width of colAddressRead (clog2 of NCOL).

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new product. Sampled at the rising edge.
- outAck, input, 1: consumer has taken outputVec.
- weightMemOutput, input, BITWIDTH*NROW: weight column, row r at [r*BITWIDTH+:BITWIDTH]. Valid 1 cycle after colAddressRead.
- inputVec, input, BITWIDTH: element x[colAddressRead]. Valid 1 cycle after colAddressRead.
- colAddressRead, output, ADDR_BITWIDTH: column being fetched.
- busy, output, 1: computation in progress.
- dataReady, output, 1: outputVec valid and held.
- outputVec, output, BITWIDTH*NROW: result, row r at [r*BITWIDTH+:BITWIDTH].

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, dataReady=0, colAddressRead=0, outputVec=0.
  - All accumulators and counters cleared.
  - Reset mid-run aborts the run; no partial result is ever flagged.
- FSM states: IDLE, FETCH, DRAIN, ROUND, DONE.
- IDLE:
  - start=1 -> FETCH.
  - colAddressRead=0, pass=0, accumulators cleared.
  - busy=1 from the next cycle.
- FETCH:
  - colAddressRead increments 0..NCOL-1, one per cycle.
  - Each cycle, the column/element returned for the previous address is multiplied and accumulated.
  - Product: signed BITWIDTH x BITWIDTH -> 2*BITWIDTH, exact.
  - Accumulator width: 2*BITWIDTH + ADDR_BITWIDTH, exact. No intermediate truncation.
  - Lane l of pass p uses row p*PAR_ROWS+l.
  - After address NCOL-1 -> DRAIN.
- DRAIN (1 cycle): accumulate the last returned column -> ROUND.
- ROUND (1 cycle):
  - For each lane: acc + 2^(QM-1), arithmetic shift right QM.
  - Saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
  - Write the result into the outputVec slice for the current pass.
  - If pass < NPASS-1: pass++, colAddressRead=0, clear accumulators -> FETCH.
  - Else -> DONE.
- DONE:
  - dataReady=1, busy=0; outputVec held stable.
  - outAck=1 -> IDLE, with dataReady=0 from the next cycle.
  - outAck=1 and start=1 in the same cycle -> FETCH directly (back-to-back run).
- Latency, with start sampled at edge 0 and NPASS=1:
  - colAddressRead=k during cycle k+1.
  - dataReady rises after edge NCOL+3.
  - Total latency = NPASS*(NCOL+2)+1 cycles.
- start handling:
  - start while busy is ignored.
  - start in DONE without outAck is ignored.
- outAck outside DONE is ignored.
- outputVec changes only on ROUND writes. Slices of earlier passes are overwritten only during a new run.

Optional Feature:
- Macro: MVM_BIAS_EN.
- When defined:
  - Extra input port biasVec, BITWIDTH*NROW, same Q format, sampled when start is accepted.
  - In ROUND, biasVec<<QM is added to each lane's accumulator before rounding and saturation.
  - Saturation applies to the biased sum.
- When undefined: no biasVec port; behaviour exactly as above.

Test Plan (QN=6, QM=11; 1.0=2048):
- Identity rows (W[r][r]=2048, else 0), NCOL=4, x=[2048, 4096, -1024, 512] -> rows 0..3 = 2048, 4096, -1024 (0x3FC00), 512; other rows 0. dataReady 7 cycles after start.
- Rounding: W[0][0]=1, x[0]=1024 -> y0=1; x[0]=1023 -> y0=0; W[0][0]=-1, x[0]=1024 -> y0=0 (round-half-up toward +inf).
- Saturation: all W=32768, all x=32768 (16.0) -> every row 0x1FFFF. Negate x -> every row 0x20000.
- Handshake: start pulsed while busy -> ignored, single result. Hold outAck=0 for 10 cycles -> outputVec and dataReady stable. outAck+start together -> next dataReady 6 cycles later (back-to-back).
- PAR_ROWS=8, NROW=32 -> colAddressRead sweeps 0..3 four times; results equal the PAR_ROWS=32 run; latency 4*6+1=25 cycles.
- Reset low during FETCH -> all outputs 0 immediately (asynchronous). After release, a fresh start gives the correct identity result. With MVM_BIAS_EN: bias=2048 on all rows plus identity case -> rows 0..3 = 4096, 6144, 1024, 2560.

Source files
------------

// File: rtl/mvm_engine.sv
`default_nettype none
// ============================================================================
// Module   : mvm_engine
// Purpose  : Matrix-vector product y = W*x for an NROW x NCOL signed Q(QN.QM)
//            matrix. Columns are streamed one per cycle from an external
//            synchronous RAM. PAR_ROWS lanes compute in parallel over
//            NROW/PAR_ROWS passes. Accumulation is exact. The result is
//            rounded half-up, saturated, and held until it is acknowledged.
// Options  : define MVM_BIAS_EN to add a per-row bias input (biasVec).
// Revision : 1.0 - initial release
// ============================================================================
module mvm_engine #(
  parameter int NROW          = 32,
  parameter int NCOL          = 4,
  parameter int QN            = 6,
  parameter int QM            = 11,
  parameter int PAR_ROWS      = 32,
  parameter int ADDR_BITWIDTH = $clog2(NCOL) + 1,
  localparam int BITWIDTH     = QN + QM + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         outAck,
  input  logic [BITWIDTH*NROW-1:0]     weightMemOutput,
  input  logic [BITWIDTH-1:0]          inputVec,
`ifdef MVM_BIAS_EN
  input  logic [BITWIDTH*NROW-1:0]     biasVec,
`endif
  output logic [ADDR_BITWIDTH-1:0]     colAddressRead,
  output logic                         busy,
  output logic                         dataReady,
  output logic [BITWIDTH*NROW-1:0]     outputVec
);

  localparam int NPASS  = NROW / PAR_ROWS;
  localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int PW     = 2 * BITWIDTH;       // exact product width
  localparam int AW     = PW + ADDR_BITWIDTH; // exact accumulator width
  localparam int SW     = AW + 1;             // headroom for bias and rounding

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE  = ADDR_BITWIDTH'(1);
  localparam logic [PASS_W-1:0]        PASS_ONE  = PASS_W'(1);

  localparam logic signed [SW-1:0] HALF    = {{(SW-QM){1'b0}}, 1'b1, {(QM-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                     state;
  logic [PASS_W-1:0]          pass;
  logic                       first_fetch;
  logic signed [AW-1:0]       acc     [PAR_ROWS];
  logic signed [PW-1:0]       prod    [PAR_ROWS];
  logic signed [SW-1:0]       sum     [PAR_ROWS];
  logic signed [SW-1:0]       shifted [PAR_ROWS];
  logic signed [BITWIDTH-1:0] rounded [PAR_ROWS];
`ifdef MVM_BIAS_EN
  logic [BITWIDTH*NROW-1:0]   bias_q;
`endif

  // Per-lane exact product of the returned weight row and the vector element
  always_comb begin
    for (int l = 0; l < PAR_ROWS; l++) begin
      prod[l] = PW'($signed(weightMemOutput[(int'(pass) * PAR_ROWS + l) * BITWIDTH +: BITWIDTH]))
              * PW'($signed(inputVec));
    end
  end

  // Per-lane (bias +) round-half-up, arithmetic shift and saturation
  always_comb begin
    for (int l = 0; l < PAR_ROWS; l++) begin
      sum[l] = SW'(acc[l]) + HALF;
`ifdef MVM_BIAS_EN
      sum[l] = sum[l]
             + (SW'($signed(bias_q[(int'(pass) * PAR_ROWS + l) * BITWIDTH +: BITWIDTH])) <<< QM);
`endif
      shifted[l] = sum[l] >>> QM;
      rounded[l] = shifted[l][BITWIDTH-1:0];
      if (shifted[l] > SAT_MAX) begin
        rounded[l] = SAT_MAX[BITWIDTH-1:0];
      end else if (shifted[l] < SAT_MIN) begin
        rounded[l] = SAT_MIN[BITWIDTH-1:0];
      end
    end
  end

  // Control FSM, address generation, accumulation and held result register.
  // Data on the memory port belongs to the address presented one cycle
  // earlier, so a FETCH cycle at address 0 never accumulates; DRAIN picks up
  // the last column. Leaving IDLE spends one extra cycle at address 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      dataReady      <= 1'b0;
      colAddressRead <= '0;
      outputVec      <= '0;
      pass           <= '0;
      first_fetch    <= 1'b0;
      for (int l = 0; l < PAR_ROWS; l++) acc[l] <= '0;
`ifdef MVM_BIAS_EN
      bias_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          colAddressRead <= '0;
          pass           <= '0;
          for (int l = 0; l < PAR_ROWS; l++) acc[l] <= '0;
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            first_fetch <= 1'b1;
`ifdef MVM_BIAS_EN
            bias_q      <= biasVec;
`endif
          end
        end
        FETCH: begin
          if (colAddressRead != '0) begin
            for (int l = 0; l < PAR_ROWS; l++) acc[l] <= acc[l] + AW'(prod[l]);
          end
          if (first_fetch) begin
            first_fetch <= 1'b0;
          end else if (colAddressRead == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            colAddressRead <= colAddressRead + ADDR_ONE;
          end
        end
        DRAIN: begin
          for (int l = 0; l < PAR_ROWS; l++) acc[l] <= acc[l] + AW'(prod[l]);
          state <= ROUND;
        end
        ROUND: begin
          for (int l = 0; l < PAR_ROWS; l++) begin
            outputVec[(int'(pass) * PAR_ROWS + l) * BITWIDTH +: BITWIDTH] <= rounded[l];
          end
          if (int'(pass) < NPASS - 1) begin
            pass           <= pass + PASS_ONE;
            colAddressRead <= '0;
            for (int l = 0; l < PAR_ROWS; l++) acc[l] <= '0;
            state          <= FETCH;
          end else begin
            state          <= DONE;
            busy           <= 1'b0;
            dataReady      <= 1'b1;
            colAddressRead <= '0;
          end
        end
        DONE: begin
          if (outAck) begin
            dataReady <= 1'b0;
            if (start) begin
              state          <= FETCH;
              busy           <= 1'b1;
              pass           <= '0;
              colAddressRead <= '0;
              for (int l = 0; l < PAR_ROWS; l++) acc[l] <= '0;
`ifdef MVM_BIAS_EN
              bias_q         <= biasVec;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvm_engine
// Purpose  : Directed, scoreboard-based bench for mvm_engine. Drives two
//            instances (PAR_ROWS=32 and PAR_ROWS=8) from behavioural
//            synchronous weight / vector memories.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvm_engine;

  localparam int NROW = 32;
  localparam int NCOL = 4;
  localparam int BW   = 18;
  localparam int AWD  = 3;

  logic clock = 1'b0;
  logic reset, start, outAck, start8, ack8;
  logic [BW*NROW-1:0] wmem, wmem8, outputVec, outputVec8;
  logic [BW-1:0]      xin, xin8;
  logic [AWD-1:0]     addr, addr8;
  logic               busy, dataReady, busy8, dataReady8;

  logic signed [BW-1:0] W [NCOL][NROW];
  logic signed [BW-1:0] X [NCOL];
  logic signed [BW-1:0] B [NROW];

  int checks = 0;
  int errors = 0;
  logic [BW*NROW-1:0] sbq  [$];
  logic [BW*NROW-1:0] sbq8 [$];
  logic [BW*NROW-1:0] last_exp;
  logic [AWD-1:0]     seen [16];

  always #5 clock = ~clock;

`ifdef MVM_BIAS_EN
  logic [BW*NROW-1:0] bias_bus;
  always_comb begin
    for (int r = 0; r < NROW; r++) bias_bus[r*BW +: BW] = B[r];
  end
`endif

  // Synchronous-read memories: data valid one cycle after the address
  always @(posedge clock) begin
    for (int r = 0; r < NROW; r++) begin
      wmem[r*BW +: BW]  <= W[addr[1:0]][r];
      wmem8[r*BW +: BW] <= W[addr8[1:0]][r];
    end
    xin  <= X[addr[1:0]];
    xin8 <= X[addr8[1:0]];
  end

  mvm_engine #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11), .PAR_ROWS(32)) dut (
    .clock(clock), .reset(reset), .start(start), .outAck(outAck),
    .weightMemOutput(wmem), .inputVec(xin),
`ifdef MVM_BIAS_EN
    .biasVec(bias_bus),
`endif
    .colAddressRead(addr), .busy(busy), .dataReady(dataReady), .outputVec(outputVec)
  );

  mvm_engine #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11), .PAR_ROWS(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .outAck(ack8),
    .weightMemOutput(wmem8), .inputVec(xin8),
`ifdef MVM_BIAS_EN
    .biasVec(bias_bus),
`endif
    .colAddressRead(addr8), .busy(busy8), .dataReady(dataReady8), .outputVec(outputVec8)
  );

  // Reference: exact dot product, bias, round half up, shift, saturate
  function automatic logic [BW*NROW-1:0] model();
    logic [BW*NROW-1:0] v;
    longint a;
    v = '0;
    for (int r = 0; r < NROW; r++) begin
      a = 0;
      for (int c = 0; c < NCOL; c++) a += longint'(W[c][r]) * longint'(X[c]);
      a += longint'(B[r]) * 2048;
      a += 1024;
      a = a >>> 11;
      if (a > 131071) a = 131071;
      else if (a < -131072) a = -131072;
      v[r*BW +: BW] = a[BW-1:0];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [BW*NROW-1:0] obs, input logic [BW*NROW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_data();
    for (int c = 0; c < NCOL; c++) begin
      X[c] = '0;
      for (int r = 0; r < NROW; r++) W[c][r] = '0;
    end
  endtask

  task automatic set_identity();
    clear_data();
    for (int r = 0; r < NCOL; r++) W[r][r] = 18'sd2048;
    X[0] = 18'sd2048; X[1] = 18'sd4096; X[2] = -18'sd1024; X[3] = 18'sd512;
  endtask

  // Launch a product on dut (called at a negedge), wait for dataReady,
  // then compare latency and result against the scoreboard head.
  task automatic run(input bit b2b, input int exp_lat, input int pulse_at, input string tag);
    int cyc;
    logic [BW*NROW-1:0] e;
    sbq.push_back(model());
    start  = 1'b1;
    outAck = b2b;
    @(posedge clock);
    cyc = 0;
    @(negedge clock);
    start  = 1'b0;
    outAck = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    while (!dataReady && cyc < 200) begin
      if (cyc < 16) seen[cyc] = addr;
      start  = (cyc == pulse_at);
      outAck = (cyc == pulse_at);
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    start  = 1'b0;
    outAck = 1'b0;
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_sbq"}, sbq.size(), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      last_exp = e;
      chkv({tag, "_result"}, outputVec, e);
    end
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic do_ack(input string tag);
    outAck = 1'b1;
    @(posedge clock);
    @(negedge clock);
    outAck = 1'b0;
    chk({tag, "_ack_ready"}, dataReady, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc8;
    int sweeps;
    logic [AWD-1:0] prev8;
    logic [BW*NROW-1:0] e8;

    reset = 1'b0; start = 1'b0; outAck = 1'b0; start8 = 1'b0; ack8 = 1'b0;
    clear_data();
    for (int r = 0; r < NROW; r++) B[r] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_ready", dataReady, 0);
    chk("rst_addr", addr, 0);
    chkv("rst_vec", outputVec, '0);
    reset = 1'b1;
    @(negedge clock);

    // Identity rows
    set_identity();
    run(1'b0, 7, -1, "ident");
    chk("ident_row0", $signed(outputVec[0*BW +: BW]), 2048);
    chk("ident_row1", $signed(outputVec[1*BW +: BW]), 4096);
    chk("ident_row2", $signed(outputVec[2*BW +: BW]), -1024);
    chk("ident_row3", $signed(outputVec[3*BW +: BW]), 512);
    chk("ident_row9", $signed(outputVec[9*BW +: BW]), 0);
    for (int k = 0; k < NCOL; k++) chk("ident_addr_seq", seen[k+1], k);
    // Result held while outAck stays low
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("hold_ready", dataReady, 1);
      chkv("hold_vec", outputVec, last_exp);
    end
    do_ack("ident");

    // Rounding cases; the second is launched back-to-back
    clear_data();
    W[0][0] = 18'sd1; X[0] = 18'sd1024;
    run(1'b0, 7, -1, "rnd_half");
    chk("rnd_half_y0", $signed(outputVec[0 +: BW]), 1);
    X[0] = 18'sd1023;
    run(1'b1, 6, -1, "rnd_below");
    chk("rnd_below_y0", $signed(outputVec[0 +: BW]), 0);
    do_ack("rnd_below");
    W[0][0] = -18'sd1; X[0] = 18'sd1024;
    run(1'b0, 7, -1, "rnd_neg");
    chk("rnd_neg_y0", $signed(outputVec[0 +: BW]), 0);
    do_ack("rnd_neg");

    // Saturation both directions
    for (int c = 0; c < NCOL; c++) begin
      X[c] = 18'sd32768;
      for (int r = 0; r < NROW; r++) W[c][r] = 18'sd32768;
    end
    run(1'b0, 7, -1, "sat_pos");
    chk("sat_pos_row5", outputVec[5*BW +: BW], 18'h1FFFF);
    for (int c = 0; c < NCOL; c++) X[c] = -18'sd32768;
    run(1'b1, 6, -1, "sat_neg");
    chk("sat_neg_row5", outputVec[5*BW +: BW], 18'h20000);
    do_ack("sat_neg");

    // start / outAck pulsed while busy: ignored, exactly one result
    set_identity();
    run(1'b0, 7, 3, "ignore");
    do_ack("ignore");
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("ignore_no_second_ready", dataReady, 0);
    chk("ignore_no_second_busy", busy, 0);

    // PAR_ROWS=8 instance: four passes, same result as the single-pass run
    sbq8.push_back(model());
    start8 = 1'b1;
    @(posedge clock);
    cyc8 = 0;
    @(negedge clock);
    start8 = 1'b0;
    prev8 = addr8;
    sweeps = 0;
    while (!dataReady8 && cyc8 < 400) begin
      @(posedge clock);
      cyc8++;
      @(negedge clock);
      if (addr8 == 3'd3 && prev8 == 3'd2) sweeps++;
      prev8 = addr8;
    end
    chk("par8_latency", cyc8, 25);
    chk("par8_sweeps", sweeps, 4);
    chk("par8_sbq", sbq8.size(), 1);
    if (sbq8.size() != 0) begin
      e8 = sbq8.pop_front();
      chkv("par8_result", outputVec8, e8);
    end
    chk("par8_row2", $signed(outputVec8[2*BW +: BW]), -1024);
    ack8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ack8 = 1'b0;
    chk("par8_ack_ready", dataReady8, 0);

    // Asynchronous reset in the middle of FETCH aborts the run
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", dataReady, 0);
    chk("arst_addr", addr, 0);
    chkv("arst_vec", outputVec, '0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run(1'b0, 7, -1, "post_rst");
    chk("post_rst_row1", $signed(outputVec[1*BW +: BW]), 4096);
    do_ack("post_rst");

`ifdef MVM_BIAS_EN
    for (int r = 0; r < NROW; r++) B[r] = 18'sd2048;
    run(1'b0, 7, -1, "bias");
    chk("bias_row0", $signed(outputVec[0*BW +: BW]), 4096);
    chk("bias_row1", $signed(outputVec[1*BW +: BW]), 6144);
    chk("bias_row2", $signed(outputVec[2*BW +: BW]), 1024);
    chk("bias_row3", $signed(outputVec[3*BW +: BW]), 2560);
    chk("bias_row7", $signed(outputVec[7*BW +: BW]), 2048);
    do_ack("bias");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
